// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr block: mode encodings and the
// channel-index width helper.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n channels, never narrower than one bit.
    function automatic int calc_sel_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: forced index (fixed mode) or round-robin search that
// starts just after the previous grant and wraps modulo N_CH.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_idx,
    output logic [SEL_W-1:0] grant,
    output logic             gnt_vld
);

    // Grant selection; the first requester found after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_vld = 1'b0;
        if (force_en) begin
            grant = force_idx;
            if (int'(force_idx) < N_CH) begin
                gnt_vld = req[force_idx];
            end else begin
                gnt_vld = 1'b0;
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                idx = (int'(last_grant) + k) % N_CH;
                if (!gnt_vld && req[idx]) begin
                    grant   = SEL_W'(idx);
                    gnt_vld = 1'b1;
                end else begin
                    grant   = grant;
                    gnt_vld = gnt_vld;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select and round-robin
// modes, valid/ready on every port and a single output register stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int N_CH  = 4,
    parameter int SEL_W = calc_sel_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [SEL_W-1:0] grant_s;
    logic             gnt_vld_s;
    logic             load_en_s;
    logic [WIDTH-1:0] ch_word_s;
    logic [SEL_W-1:0] last_grant_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_ch_r;
    logic             out_valid_r;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant_r),
        .force_en   (mode == MODE_FIXED),
        .force_idx  (sel),
        .grant      (grant_s),
        .gnt_vld    (gnt_vld_s)
    );

    assign load_en_s = !out_valid_r || out_ready;

    // Data mux for the granted channel.
    always_comb begin
        ch_word_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_s == SEL_W'(i)) begin
                ch_word_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                ch_word_s = ch_word_s;
            end
        end
    end

    // One-hot ready to the granted producer; suppressed while reset is held.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = rst_n & load_en_s & gnt_vld_s & (grant_s == SEL_W'(i));
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_ch_r     <= '0;
            last_grant_r <= SEL_W'(N_CH - 1);
        end else if (load_en_s) begin
            if (gnt_vld_s) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= ch_word_s;
                out_ch_r     <= grant_s;
                last_grant_r <= grant_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else begin
            out_valid_r  <= out_valid_r;
            out_data_r   <= out_data_r;
            out_ch_r     <= out_ch_r;
            last_grant_r <= last_grant_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus random
// traffic compared against a behavioural reference model.
module tb_stream_mux_rr;

    localparam int WIDTH = 3;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;

    int n_cmp;
    int n_err;

    // reference model state
    int m_last;
    int m_valid;
    int m_data;
    int m_ch;
    int ch_word[N_CH];

    stream_mux_rr #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put_data();
        for (int i = 0; i < N_CH; i++) begin
            in_data[i*WIDTH +: WIDTH] = WIDTH'(ch_word[i]);
        end
    endtask

    task automatic model_reset();
        m_last  = N_CH - 1;
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
    endtask

    // Which channel would the spec's rules pick right now?
    task automatic ref_grant(output int g, output int gv);
        g  = 0;
        gv = 0;
        if (mode == 1'b0) begin
            g  = int'(sel);
            gv = (g < N_CH) ? int'(in_valid[g]) : 0;
        end else begin
            for (int k = 1; k <= N_CH && gv == 0; k++) begin
                if (in_valid[(m_last + k) % N_CH]) begin
                    g  = (m_last + k) % N_CH;
                    gv = 1;
                end
            end
        end
    endtask

    // One clock cycle: inputs are already driven (just after a negedge).
    task automatic step();
        int g, gv, ld, exp_ir;
        #1;
        ref_grant(g, gv);
        ld     = (m_valid == 0 || out_ready) ? 1 : 0;
        exp_ir = (ld != 0 && gv != 0) ? (1 << g) : 0;
        chk("in_ready", int'(in_ready), exp_ir);
        chk("out_valid", int'(out_valid), m_valid);
        chk("out_data", int'(out_data), m_data);
        chk("out_ch", int'(out_ch), m_ch);
        @(posedge clk);
        if (ld != 0) begin
            if (gv != 0) begin
                m_valid = 1;
                m_data  = ch_word[g];
                m_ch    = g;
                m_last  = g;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();

        // reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < N_CH; i++) ch_word[i] = $urandom_range(7, 0);
        put_data();
        in_valid  = N_CH'($urandom);
        mode      = 1'($urandom);
        sel       = SEL_W'($urandom);
        out_ready = 1'($urandom);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // RR fairness: all valid, ch_i carries i
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) ch_word[i] = i;
        put_data();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_seq_ch", int'(out_ch), k % N_CH);
            chk("rr_seq_data", int'(out_data), k % N_CH);
        end

        // FIXED mode, sel=2
        mode = 1'b0; sel = 2'd2; ch_word[2] = 5; put_data();
        #1;
        chk("fix_in_ready", int'(in_ready), 4);
        step();
        chk("fix_data", int'(out_data), 5);
        chk("fix_ch", int'(out_ch), 2);
        chk("fix_valid", int'(out_valid), 1);

        // backpressure: held word frozen, then next RR channel (3) loads
        mode = 1'b1; out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_ch", int'(out_ch), 2);
            chk("bp_data", int'(out_data), 5);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_ch", int'(out_ch), 3);

        // sparse and wrap from last_grant=3
        in_valid = 4'b0100; step();
        chk("sparse_ch", int'(out_ch), 2);
        in_valid = 4'b0001; step();
        chk("wrap_ch", int'(out_ch), 0);
        in_valid = 4'b0000; step();
        chk("drain_valid", int'(out_valid), 0);
        step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_CH; i++) ch_word[i] = $urandom_range(7, 0);
            put_data();
            in_valid  = N_CH'($urandom);
            mode      = 1'($urandom);
            sel       = SEL_W'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            step();
        end

        // reset while holding a stalled word
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; step();
        out_ready = 1'b0; step();
        chk("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ch", int'(out_ch), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
